sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-port arbiter and access sequencer for the board's 1M x 16 asynchronous SRAM. It sits between the external SRAM pins and two on-chip requesters: port A, the display refresh reader, and port B, the game logic board-state reader/writer. It serialises their single-word requests and drives the SRAM strobes with a fixed, parameterised access window. Port A has fixed priority, and a starvation counter guarantees port B forward progress.

## Interface
- ADDR_W, 20, SRAM word address width
- DATA_W, 16, SRAM data width
- WAIT_CYCLES, 1, extra cycles the strobe stays asserted beyond the first (access window = WAIT_CYCLES+1 cycles)
- STARVE_MAX, 4, consecutive port-B losses after which B wins the next arbitration
- clk_clk  in  1  single system clock; all logic on rising edge
- reset_reset_n  in  1  asynchronous, active-low reset
- a_req / b_req  in  1  request; held high with fields stable until matching ack
- a_we / b_we  in  1  1 = write, 0 = read
- a_addr / b_addr  in  ADDR_W  word address
- a_wdata / b_wdata  in  DATA_W  write data
- a_be / b_be  in  2  byte enables for writes ([0] low byte, [1] high byte); ignored on reads
- a_ack / b_ack  out  1  one-cycle completion pulse
- a_rdata / b_rdata  out  DATA_W  read data; valid in the ack cycle and held until the port's next read completes
- sram_DQ  inout  16  SRAM data bus
- sram_ADDR  out  20  SRAM address
- sram_CE_N, sram_OE_N, sram_WE_N, sram_LB_N, sram_UB_N  out  1  active-low SRAM strobes

## Operation
- FSM states: IDLE, ACCESS, RECOVER.
- IDLE:
  - If any req is high, arbitrate and latch the winner's we/addr/wdata/be into internal registers.
  - Drive sram_ADDR and assert the strobes on the same edge, load cnt = WAIT_CYCLES, then go to ACCESS.
  - With no request, stay in IDLE.
- Arbitration:
  - A only: A wins. B only: B wins.
  - Both requesting: A wins unless starve_cnt == STARVE_MAX, in which case B wins.
  - starve_cnt increments (saturating at STARVE_MAX) when B is requesting and A wins; it clears whenever B is granted.
- ACCESS:
  - CE_N = 0.
  - Read: OE_N = 0, LB_N = UB_N = 0, DQ high-Z.
  - Write: WE_N = 0, LB_N = ~be[0], UB_N = ~be[1], DQ driven with wdata.
  - cnt decrements each cycle. When cnt == 0: for a read, capture sram_DQ into the winner's rdata register; go to RECOVER.
- RECOVER:
  - All strobes return high.
  - For a write, DQ stays driven for this cycle as data hold time, then goes high-Z.
  - The winner's ack pulses high for this one cycle. Next state is IDLE.
- Requester rule: a req still high in the cycle after its ack is treated as a new request.
- Reset values:
  - sram_CE_N/OE_N/WE_N/LB_N/UB_N = 1.
  - sram_ADDR = 0, DQ high-Z.
  - a_ack = b_ack = 0, a_rdata = b_rdata = 0.
  - FSM = IDLE, starve_cnt = 0.
- Reset asserted mid-access: strobes go high and DQ goes high-Z immediately (asynchronous). The transaction is dropped with no ack, and requesters must re-issue.
- sram_ADDR holds its last value in IDLE.

## Timing
- All SRAM pins and acks are driven directly from registers, with no combinational path from req to pins.
- Request sampled high in IDLE at edge 0:
  - ACCESS occupies edges 1..WAIT_CYCLES+1.
  - ack is high after edge WAIT_CYCLES+2.
  - Default latency is 3 cycles.
- Back-to-back throughput: one access per WAIT_CYCLES+3 cycles (4 cycles at default).
- Read data is sampled on the last ACCESS edge, while OE_N is still low.
- Address and data are stable for the whole strobe window. Address is set up on the same edge the strobe falls, which the SRAM's 0 ns tSA permits.
- Worst-case B wait under continuous A traffic: STARVE_MAX+1 access slots.

## Test plan
- Single B write then read, default params: b_addr=0x00123, b_wdata=0xBEEF, be=2'b11. Expect WE_N low for exactly 2 cycles and b_ack 3 cycles after req. Then a read of 0x00123 returns b_rdata=0xBEEF with b_ack 3 cycles after req; a_ack stays 0 throughout.
- Byte write: write 0x1234 to addr 5, then write 0xAB00 with be=2'b10. Expect UB_N=0 and LB_N=1 during ACCESS; a readback returns 0xAB34.
- Simultaneous requests: a_req and b_req rise on the same edge. Expect A acked first and B acked exactly 4 cycles later; no cycle with both acks high.
- Starvation: A requests continuously, B requests continuously from cycle 0. Expect B granted after exactly 4 A grants, then the sequence A,A,A,A,B repeating; starve_cnt clears at each B grant.
- Reset mid-write: deassert reset_reset_n during ACCESS. Expect WE_N=1 and DQ high-Z in the same cycle, no ack. After release, a read of that address succeeds normally.
- WAIT_CYCLES=3 build: read latency is 5 cycles, OE_N is low for 4 cycles, and throughput is one access per 6 cycles.

Source files
------------

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port fixed-priority arbiter and access sequencer for an async SRAM
//
// Serialises single-word requests from port A (display refresh, high priority)
// and port B (game logic) onto a 1M x 16 asynchronous SRAM. Each access holds
// the strobes low for WAIT_CYCLES+1 cycles, followed by one recovery cycle in
// which the winner is acked. A starvation counter lets B win after STARVE_MAX
// consecutive losses so it always makes forward progress.
//
// Ports:
//   clk_clk, reset_reset_n          clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata/a_be  port A request (held until a_ack)
//   a_ack, a_rdata                  port A one-cycle completion, read data
//   b_*                             port B, same meaning as port A
//   sram_DQ                         bidirectional SRAM data bus
//   sram_ADDR                       SRAM word address
//   sram_CE_N/OE_N/WE_N/LB_N/UB_N   active-low SRAM strobes
module sram_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1,
    parameter int STARVE_MAX  = 4
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [1:0]        a_be,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic [1:0]        b_be,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    inout  wire  [DATA_W-1:0] sram_DQ,
    output logic [ADDR_W-1:0] sram_ADDR,
    output logic              sram_CE_N,
    output logic              sram_OE_N,
    output logic              sram_WE_N,
    output logic              sram_LB_N,
    output logic              sram_UB_N
);

    localparam int CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt;
    logic [STARVE_W-1:0] starve_cnt;

    // Latched transaction of the current winner
    logic                sel_b;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                dq_oe;

    // Arbitration
    logic                grant;
    logic                b_win;
    logic                win_we;
    logic [1:0]          win_be;

    // Next values of the registered pin/ack outputs
    logic                ce_n_d, oe_n_d, we_n_d, lb_n_d, ub_n_d;
    logic                dq_oe_d, a_ack_d, b_ack_d;

    always_comb begin
        grant  = (state == IDLE) && (a_req || b_req);
        b_win  = b_req && (!a_req || (starve_cnt == STARVE_W'(STARVE_MAX)));
        win_we = b_win ? b_we : a_we;
        win_be = b_win ? b_be : a_be;
    end

    // State register
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant) state_next = ACCESS;
            ACCESS:  if (cnt == '0) state_next = RECOVER;
            RECOVER: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: computes the next value of every registered pin so that
    // the SRAM strobes and acks come straight from flops.
    always_comb begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        a_ack_d = 1'b0;
        b_ack_d = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    ce_n_d = 1'b0;
                    if (win_we) begin
                        we_n_d  = 1'b0;
                        lb_n_d  = ~win_be[0];
                        ub_n_d  = ~win_be[1];
                        dq_oe_d = 1'b1;
                    end else begin
                        oe_n_d = 1'b0;
                        lb_n_d = 1'b0;
                        ub_n_d = 1'b0;
                    end
                end
            end
            ACCESS: begin
                // Write data stays on the bus through RECOVER as hold time
                dq_oe_d = we_q;
                if (cnt != '0) begin
                    ce_n_d = sram_CE_N;
                    oe_n_d = sram_OE_N;
                    we_n_d = sram_WE_N;
                    lb_n_d = sram_LB_N;
                    ub_n_d = sram_UB_N;
                end else begin
                    a_ack_d = ~sel_b;
                    b_ack_d = sel_b;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cnt        <= '0;
            starve_cnt <= '0;
            sel_b      <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            dq_oe      <= 1'b0;
            sram_ADDR  <= '0;
            sram_CE_N  <= 1'b1;
            sram_OE_N  <= 1'b1;
            sram_WE_N  <= 1'b1;
            sram_LB_N  <= 1'b1;
            sram_UB_N  <= 1'b1;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            a_rdata    <= '0;
            b_rdata    <= '0;
        end else begin
            sram_CE_N <= ce_n_d;
            sram_OE_N <= oe_n_d;
            sram_WE_N <= we_n_d;
            sram_LB_N <= lb_n_d;
            sram_UB_N <= ub_n_d;
            dq_oe     <= dq_oe_d;
            a_ack     <= a_ack_d;
            b_ack     <= b_ack_d;

            if (grant) begin
                sel_b     <= b_win;
                we_q      <= win_we;
                wdata_q   <= b_win ? b_wdata : a_wdata;
                sram_ADDR <= b_win ? b_addr : a_addr;
                cnt       <= CNT_W'(WAIT_CYCLES);
                if (b_win) begin
                    starve_cnt <= '0;
                end else if (b_req && (starve_cnt != STARVE_W'(STARVE_MAX))) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end

            if (state == ACCESS) begin
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else if (!we_q) begin
                    // Last ACCESS edge: OE_N is still low, bus holds SRAM data
                    if (sel_b) begin
                        b_rdata <= sram_DQ;
                    end else begin
                        a_rdata <= sram_DQ;
                    end
                end
            end
        end
    end

    assign sram_DQ = dq_oe ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard testbench for sram_arbiter
module tb_sram_arbiter;

    localparam int WAIT = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        a_req, a_we, b_req, b_we;
    logic [19:0] a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic [1:0]  a_be, b_be;
    logic        a_ack, b_ack;
    logic [15:0] a_rdata, b_rdata;
    tri1  [15:0] dq;
    logic [19:0] sram_addr;
    logic        ce_n, oe_n, we_n, lb_n, ub_n;

    sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(WAIT), .STARVE_MAX(4)) u_dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .sram_DQ(dq), .sram_ADDR(sram_addr),
        .sram_CE_N(ce_n), .sram_OE_N(oe_n), .sram_WE_N(we_n),
        .sram_LB_N(lb_n), .sram_UB_N(ub_n)
    );

    // Second build with a longer access window; only port B is exercised
    logic        x_b_req, x_b_we;
    logic [19:0] x_b_addr;
    logic        x_a_ack, x_b_ack;
    logic [15:0] x_a_rdata, x_b_rdata;
    tri1  [15:0] x_dq;
    logic [19:0] x_addr;
    logic        x_ce_n, x_oe_n, x_we_n, x_lb_n, x_ub_n;

    sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(3), .STARVE_MAX(4)) u_dut3 (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .a_req(1'b0), .a_we(1'b0), .a_addr(20'h0), .a_wdata(16'h0), .a_be(2'b00),
        .a_ack(x_a_ack), .a_rdata(x_a_rdata),
        .b_req(x_b_req), .b_we(x_b_we), .b_addr(x_b_addr), .b_wdata(16'h0), .b_be(2'b00),
        .b_ack(x_b_ack), .b_rdata(x_b_rdata),
        .sram_DQ(x_dq), .sram_ADDR(x_addr),
        .sram_CE_N(x_ce_n), .sram_OE_N(x_oe_n), .sram_WE_N(x_we_n),
        .sram_LB_N(x_lb_n), .sram_UB_N(x_ub_n)
    );

    // SRAM models
    logic [15:0] mem [0:4095];
    assign dq   = (!ce_n && !oe_n && we_n) ? mem[sram_addr[11:0]] : 16'hzzzz;
    assign x_dq = (!x_ce_n && !x_oe_n && x_we_n) ? ~x_addr[15:0] : 16'hzzzz;

    always @(posedge clk) begin
        if (rst_n && !ce_n && !we_n) begin
            if (!lb_n) mem[sram_addr[11:0]][7:0]  <= dq[7:0];
            if (!ub_n) mem[sram_addr[11:0]][15:8] <= dq[15:8];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        port;
        logic        we;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] rdata;
        int          exp_cyc;
    } item_t;

    item_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: checks the pins of the active access against the queue head
    // and retires the head on each ack.
    int run = 0;
    always @(negedge clk) begin
        item_t t;
        if (!rst_n) begin
            run = 0;
        end else begin
            if (!ce_n) begin
                run++;
                if (sb.size() == 0) begin
                    fail("access_without_request");
                end else begin
                    t = sb[0];
                    check("strobes", {sram_addr, we_n, oe_n, lb_n, ub_n},
                          {t.addr, ~t.we, t.we, t.we ? ~t.be[0] : 1'b0, t.we ? ~t.be[1] : 1'b0});
                    if (t.we) check("write_dq", dq, t.wdata);
                end
            end else if (run != 0) begin
                check("strobe_width", run, WAIT + 1);
                run = 0;
            end
            if (a_ack || b_ack) begin
                check("ack_exclusive", a_ack & b_ack, 0);
                if (sb.size() == 0) begin
                    fail("unexpected_ack");
                end else begin
                    t = sb.pop_front();
                    check("ack_port", b_ack, t.port);
                    if (t.exp_cyc >= 0) check("ack_cycle", cyc, t.exp_cyc);
                    if (t.we) check("write_hold_dq", dq, t.wdata);
                    else      check("rdata", t.port ? b_rdata : a_rdata, t.rdata);
                end
            end
        end
    end

    task automatic drive(input logic port, input logic we, input logic [19:0] addr,
                         input logic [15:0] wdata, input logic [1:0] be);
        if (port) begin
            b_we = we; b_addr = addr; b_wdata = wdata; b_be = be; b_req = 1'b1;
        end else begin
            a_we = we; a_addr = addr; a_wdata = wdata; a_be = be; a_req = 1'b1;
        end
    endtask

    task automatic wait_ack(input logic port);
        bit done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            #1;
            if (port ? b_ack : a_ack) done = 1;
        end
        if (port) b_req = 1'b0; else a_req = 1'b0;
        if (!done) fail(port ? "b_ack_timeout" : "a_ack_timeout");
    endtask

    task automatic single(input logic port, input logic we, input logic [19:0] addr,
                          input logic [15:0] wdata, input logic [1:0] be, input logic [15:0] rdata);
        @(posedge clk);
        #1;
        sb.push_back('{port, we, addr, wdata, be, rdata, cyc + 3});
        drive(port, we, addr, wdata, be);
        wait_ack(port);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int base, cnt, n, oe, first, second, issue;
        bit seen;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
        rst_n = 1'b0;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_be = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_be = 0;
        x_b_req = 0; x_b_we = 0; x_b_addr = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_strobes", {ce_n, oe_n, we_n, lb_n, ub_n}, 5'b11111);
        check("rst_addr", sram_addr, 0);
        check("rst_dq", dq, 16'hFFFF);
        check("rst_acks", {a_ack, b_ack}, 0);
        check("rst_rdata", {a_rdata, b_rdata}, 0);
        @(negedge clk) rst_n = 1'b1;

        // B write then read, full-word
        single(1, 1, 20'h00123, 16'hBEEF, 2'b11, 16'h0);
        single(1, 0, 20'h00123, 16'h0,    2'b00, 16'hBEEF);
        // Byte-lane write
        single(0, 1, 20'h00005, 16'h1234, 2'b11, 16'h0);
        single(0, 1, 20'h00005, 16'hAB00, 2'b10, 16'h0);
        single(1, 0, 20'h00005, 16'h0,    2'b00, 16'hAB34);

        // Simultaneous requests: A first, B one slot (4 cycles) later
        @(posedge clk);
        #1;
        sb.push_back('{1'b0, 1'b0, 20'h00005, 16'h0,    2'b00, 16'hAB34, cyc + 3});
        sb.push_back('{1'b1, 1'b1, 20'h00123, 16'h5555, 2'b11, 16'h0,    cyc + 7});
        drive(0, 0, 20'h00005, 16'h0, 2'b00);
        drive(1, 1, 20'h00123, 16'h5555, 2'b11);
        fork
            wait_ack(0);
            wait_ack(1);
        join

        // Starvation: both continuous, expect A,A,A,A,B twice
        @(posedge clk);
        #1;
        base = cyc;
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) sb.push_back('{1'b1, 1'b1, 20'h00300, 16'h0B0B, 2'b11, 16'h0, base + 3 + 4 * i});
            else            sb.push_back('{1'b0, 1'b1, 20'h00200, 16'h0A0A, 2'b11, 16'h0, base + 3 + 4 * i});
        end
        drive(0, 1, 20'h00200, 16'h0A0A, 2'b11);
        drive(1, 1, 20'h00300, 16'h0B0B, 2'b11);
        cnt = 0;
        for (int i = 0; i < 80 && cnt < 10; i++) begin
            @(posedge clk);
            #1;
            if (a_ack || b_ack) cnt++;
        end
        a_req = 1'b0;
        b_req = 1'b0;
        check("starve_ack_count", cnt, 10);
        single(0, 0, 20'h00300, 16'h0, 2'b00, 16'h0B0B);

        // Reset in the middle of a write
        single(0, 1, 20'h00077, 16'h1111, 2'b11, 16'h0);
        @(posedge clk);
        #1;
        sb.push_back('{1'b0, 1'b1, 20'h00077, 16'h2222, 2'b11, 16'h0, -1});
        drive(0, 1, 20'h00077, 16'h2222, 2'b11);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (!ce_n) seen = 1;
        end
        check("reset_access_started", seen, 1);
        #2;
        rst_n = 1'b0;
        a_req = 1'b0;
        #1;
        check("reset_strobes", {ce_n, we_n, oe_n}, 3'b111);
        check("reset_dq", dq, 16'hFFFF);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        check("reset_rdata", a_rdata, 0);
        repeat (4) @(posedge clk);
        single(0, 0, 20'h00077, 16'h0, 2'b00, 16'h1111);

        // WAIT_CYCLES=3 build: two back-to-back B reads
        @(posedge clk);
        #1;
        issue = cyc;
        x_b_we = 1'b0;
        x_b_addr = 20'h00010;
        x_b_req = 1'b1;
        n = 0; oe = 0; first = -1; second = -1;
        for (int i = 0; i < 40 && n < 2; i++) begin
            @(posedge clk);
            #1;
            if (!x_oe_n) oe++;
            if (x_b_ack) begin
                n++;
                if (n == 1) first = cyc; else second = cyc;
            end
        end
        x_b_req = 1'b0;
        check("w3_latency", first - issue, 5);
        check("w3_period", second - first, 6);
        check("w3_oe_width", oe, 8);
        check("w3_rdata", x_b_rdata, 16'hFFEF);

        repeat (6) @(posedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
